// File: rtl/random_arbiter.sv
// Fibonacci LFSR: loads on i_Seed_DV and shifts one step per enabled cycle.
// Latency: the new value is visible the cycle after load or shift. No backpressure.
// An all-zero state locks the register, so the parent must not load a zero seed.
module lfsr #(
  parameter int NUM_BITS = 8
) (
  input  logic                i_Clk,
  input  logic                i_Enable,
  input  logic                i_Seed_DV,
  input  logic [NUM_BITS-1:0] i_Seed_Data,
  output logic [NUM_BITS-1:0] o_LFSR_Data
);

  // Maximal-length tap masks; bit k set means stage k+1 feeds the XOR.
  function automatic logic [31:0] taps_for(input int n);
    case (n)
      4:       taps_for = 32'h0000_000C;
      5:       taps_for = 32'h0000_0014;
      6:       taps_for = 32'h0000_0030;
      7:       taps_for = 32'h0000_0060;
      8:       taps_for = 32'h0000_00B8;
      16:      taps_for = 32'h0000_D008;
      default: taps_for = 32'h0000_0003 << (n - 2);
    endcase
  endfunction

  localparam logic [NUM_BITS-1:0] TAPS = NUM_BITS'(taps_for(NUM_BITS));

  logic [NUM_BITS-1:0] lfsr_q;

  always_ff @(posedge i_Clk) begin
    if (i_Seed_DV) begin
      lfsr_q <= i_Seed_Data;
    end else if (i_Enable) begin
      lfsr_q <= {lfsr_q[NUM_BITS-2:0], ^(lfsr_q & TAPS)};
    end
  end

  assign o_LFSR_Data = lfsr_q;

endmodule

// Shares one LFSR among NUM_REQ requesters, one fresh word per grant, round-robin.
// Latency: a request seen in READY is granted NUM_STEPS+1 cycles later.
// Backpressure: requests are level-held and only accepted in READY; reseed waits for READY.
module random_arbiter #(
  parameter int                  NUM_BITS  = 8,
  parameter int                  NUM_REQ   = 4,
  parameter int                  NUM_STEPS = 8,
  parameter int                  WARMUP    = 16,
  parameter logic [NUM_BITS-1:0] SEED_DFLT = {1'b1, {(NUM_BITS-1){1'b0}}}
) (
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  input  logic [NUM_REQ-1:0]  i_Req,
  output logic [NUM_REQ-1:0]  o_Gnt,
  output logic                o_Valid,
  output logic [NUM_BITS-1:0] o_Data,
  input  logic                i_Reseed,
  input  logic [NUM_BITS-1:0] i_Seed,
  output logic                o_Ready
);

  localparam int CNT_MAX = (WARMUP > NUM_STEPS) ? WARMUP : NUM_STEPS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PTR_W   = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    S_SEED,
    S_WARMUP,
    S_READY,
    S_STEP,
    S_GRANT
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    rr_q, rr_d;
  logic [PTR_W-1:0]    win_q, win_d;
  logic                pend_q, pend_d;
  logic [NUM_BITS-1:0] seed_q, seed_d;
  logic                vld_q, vld_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_BITS-1:0] data_q;

  logic                win_vld;
  logic [PTR_W-1:0]    win_idx;
  int unsigned         idx;
  logic [NUM_BITS-1:0] lfsr_data;

  lfsr #(
    .NUM_BITS (NUM_BITS)
  ) u_lfsr (
    .i_Clk       (i_Clk),
    .i_Enable    (state_q == S_SEED || state_q == S_WARMUP || state_q == S_STEP),
    .i_Seed_DV   (state_q == S_SEED),
    .i_Seed_Data (seed_q),
    .o_LFSR_Data (lfsr_data)
  );

  // First requester at or above the rr pointer, wrapping.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_q) + i) % NUM_REQ;
      if (!win_vld && i_Req[idx]) begin
        win_vld = 1'b1;
        win_idx = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    win_d   = win_q;
    vld_d   = 1'b0;
    gnt_d   = '0;
    case (state_q)
      S_SEED: begin
        state_d = S_WARMUP;
        cnt_d   = CNT_W'(WARMUP - 1);
      end
      S_WARMUP: begin
        if (cnt_q == '0) begin
          state_d = S_READY;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_READY: begin
        if (pend_q) begin
          state_d = S_SEED;
          cnt_d   = '0;
        end else if (win_vld) begin
          state_d = S_STEP;
          win_d   = win_idx;
          cnt_d   = CNT_W'(NUM_STEPS - 1);
        end
      end
      S_STEP: begin
        if (cnt_q == '0) begin
          state_d = S_GRANT;
          vld_d   = 1'b1;
          gnt_d   = NUM_REQ'(1) << win_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_GRANT: begin
        state_d = S_READY;
        rr_d    = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + PTR_W'(1);
      end
      default: begin
        state_d = S_SEED;
      end
    endcase
  end

  // A new pulse wins over the clear so a reseed arriving on the SEED entry is not lost.
  always_comb begin
    pend_d = pend_q;
    seed_d = seed_q;
    if (state_q == S_READY && pend_q) begin
      pend_d = 1'b0;
    end
    if (i_Reseed) begin
      pend_d = 1'b1;
      seed_d = (i_Seed == '0) ? SEED_DFLT : i_Seed;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= S_SEED;
      cnt_q   <= '0;
      rr_q    <= '0;
      win_q   <= '0;
      pend_q  <= 1'b0;
      seed_q  <= SEED_DFLT;
      vld_q   <= 1'b0;
      gnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      pend_q  <= pend_d;
      seed_q  <= seed_d;
      vld_q   <= vld_d;
      gnt_q   <= gnt_d;
      if (state_q == S_GRANT) begin
        data_q <= lfsr_data;
      end
    end
  end

  // The LFSR is frozen during GRANT, so the drawn word can be shown directly.
  assign o_Data  = (state_q == S_GRANT) ? lfsr_data : data_q;
  assign o_Valid = vld_q;
  assign o_Gnt   = gnt_q;
  assign o_Ready = (state_q == S_READY);

endmodule

// File: tb/tb_random_arbiter.sv
// Randomized bench for random_arbiter against a transaction-level model of draws and rr order.
module tb_random_arbiter;

  localparam int NB = 8;
  localparam int NR = 4;
  localparam int NS = 8;
  localparam int WU = 16;

  logic          i_Clk    = 1'b0;
  logic          i_Rst_n  = 1'b1;
  logic [NR-1:0] i_Req    = '0;
  logic          i_Reseed = 1'b0;
  logic [NB-1:0] i_Seed   = '0;
  logic [NR-1:0] o_Gnt;
  logic          o_Valid;
  logic [NB-1:0] o_Data;
  logic          o_Ready;

  always #5 i_Clk = ~i_Clk;

  random_arbiter #(
    .NUM_BITS  (NB),
    .NUM_REQ   (NR),
    .NUM_STEPS (NS),
    .WARMUP    (WU)
  ) dut (
    .i_Clk    (i_Clk),
    .i_Rst_n  (i_Rst_n),
    .i_Req    (i_Req),
    .o_Gnt    (o_Gnt),
    .o_Valid  (o_Valid),
    .o_Data   (o_Data),
    .i_Reseed (i_Reseed),
    .i_Seed   (i_Seed),
    .o_Ready  (o_Ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: LFSR polynomial x^8+x^6+x^5+x^4+1, advanced by whole draws.
  logic [NB-1:0] m_lfsr;
  int            m_ptr;

  function automatic logic [NB-1:0] m_adv(input logic [NB-1:0] x, input int n);
    int v;
    v = int'(x);
    for (int k = 0; k < n; k++) v = ((v * 2) % 256) + ($countones(v & 'hB8) % 2);
    return NB'(v);
  endfunction

  function automatic int m_pick(input logic [NR-1:0] req);
    int j;
    for (int i = 0; i < NR; i++) begin
      j = (m_ptr + i) % NR;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  task automatic m_seed(input logic [NB-1:0] s);
    m_lfsr = m_adv((s == '0) ? 8'h80 : s, WU);
  endtask

  int viol     = 0;
  int vld_seen = 0;
  always @(negedge i_Clk) begin
    if (o_Valid === 1'b1) vld_seen++;
    if ($countones(o_Gnt) > 1 || ((o_Gnt != '0) != o_Valid)) viol++;
  end

  task automatic wait_ready(output int n);
    n = 0;
    while (o_Ready !== 1'b1 && n < 200) begin
      @(negedge i_Clk);
      n++;
    end
  endtask

  // Caller is at a negedge with the DUT in READY.
  task automatic draw(input logic [NR-1:0] req, input bit drop, input int rs_at,
                      input logic [NB-1:0] rs_val, input string tag);
    int n, w;
    logic [NR-1:0] eg;
    logic [NB-1:0] ed;
    n  = 0;
    w  = m_pick(req);
    eg = NR'(1) << w;
    m_lfsr = m_adv(m_lfsr, NS);
    ed = m_lfsr;
    m_ptr = (w + 1) % NR;
    i_Req = req;
    while (o_Valid !== 1'b1 && n < 50) begin
      @(negedge i_Clk);
      n++;
      if (drop) i_Req = '0;
      i_Reseed = (n == rs_at);
      if (n == rs_at) i_Seed = rs_val;
    end
    i_Req    = '0;
    i_Reseed = 1'b0;
    check({tag, "_latency"}, n, NS + 1);
    check({tag, "_gnt"}, o_Gnt, eg);
    check({tag, "_data"}, o_Data, ed);
    @(negedge i_Clk);
    check({tag, "_pulse_end"}, {o_Valid, o_Gnt}, '0);
  endtask

  task automatic reseed_gap(input logic [NB-1:0] sv, input string tag);
    int n;
    check({tag, "_ready_before"}, o_Ready, 1);
    @(negedge i_Clk);
    wait_ready(n);
    check({tag, "_ready_low"}, n, 1 + WU);
    m_seed(sv);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, last, w, vs;
    logic [NB-1:0] prev;
    logic [NR-1:0] rq;
    bit            dr;
    int            rs;
    logic [NB-1:0] sv;

    #1 i_Rst_n = 1'b0;
    repeat (2) @(negedge i_Clk);
    check("rst_gnt", o_Gnt, 0);
    check("rst_valid", o_Valid, 0);
    check("rst_data", o_Data, 0);
    check("rst_ready", o_Ready, 0);

    // SEED occupies the cycle after release, then WARMUP cycles.
    i_Rst_n = 1'b1;
    wait_ready(n);
    check("ready_after_reset", n, 1 + WU);
    m_ptr = 0;
    m_seed('0);

    // All requesters held: round-robin, one grant every NS+2 cycles.
    i_Req = '1;
    n = 0; k = 0; last = 0; prev = '0;
    while (k < 5 && n < 200) begin
      @(negedge i_Clk);
      n++;
      if (o_Valid === 1'b1) begin
        w = m_pick('1);
        m_lfsr = m_adv(m_lfsr, NS);
        m_ptr = (w + 1) % NR;
        check("b2b_gnt", o_Gnt, NR'(1) << w);
        check("b2b_data", o_Data, m_lfsr);
        check("b2b_spacing", n - last, (k == 0) ? NS + 1 : NS + 2);
        if (k > 0) check("b2b_distinct", o_Data != prev, 1);
        prev = o_Data;
        last = n;
        k++;
        if (k == 5) i_Req = '0;
      end
    end
    i_Req = '0;
    check("b2b_count", k, 5);
    @(negedge i_Clk);

    draw(4'b0100, 1'b0, 0, '0, "single");

    // Reseed mid-STEP: in-flight draw completes on the old sequence.
    draw(4'b0001, 1'b0, 4, 8'h5A, "reseed5a");
    reseed_gap(8'h5A, "reseed5a");
    draw(4'b0010, 1'b0, 0, '0, "after5a");
    draw(4'b1000, 1'b0, 3, 8'h00, "reseed00");
    reseed_gap(8'h00, "reseed00");
    draw(4'b0110, 1'b0, 0, '0, "after00");

    // Reset in the middle of a STEP sequence.
    i_Req = 4'b0001;
    repeat (3) @(negedge i_Clk);
    i_Req = '0;
    check("pre_reset_data_nonzero", o_Data != '0, 1);
    vs = vld_seen;
    #2 i_Rst_n = 1'b0;
    #1;
    check("midrst_gnt", o_Gnt, 0);
    check("midrst_valid", o_Valid, 0);
    check("midrst_data", o_Data, 0);
    repeat (3) @(negedge i_Clk);
    i_Rst_n = 1'b1;
    wait_ready(n);
    check("midrst_ready", n, 1 + WU);
    check("midrst_no_grant", vld_seen, vs);
    m_ptr = 0;
    m_seed('0);
    draw(4'b1111, 1'b0, 0, '0, "midrst_draw");

    // One-cycle request still served, then idle.
    draw(4'b0010, 1'b1, 0, '0, "short_req");
    vs = vld_seen;
    repeat (30) @(negedge i_Clk);
    check("idle_no_valid", vld_seen, vs);
    check("idle_ready", o_Ready, 1);

    for (int it = 0; it < 24; it++) begin
      rq = NR'($urandom_range(1, 15));
      dr = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
      sv = ($urandom_range(0, 2) == 0) ? '0 : NB'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge i_Clk);
      draw(rq, dr, rs, sv, "rand");
      if (rs != 0) reseed_gap(sv, "rand");
    end

    check("monitor_violations", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
